// File: rtl/sha256_pkg.sv
// Shared types, constants and padding helper for the SHA-256 message padder.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_DATA   = 3'd0,
    ST_ONE    = 3'd1,
    ST_ZERO   = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_LEN_LO = 3'd4
  } pad_state_e;

  localparam int          WORD_W          = 32;
  localparam int          WORDS_PER_BLOCK = 16;
  localparam logic [3:0]  LEN_HI_IDX      = 4'd14;
  localparam logic [3:0]  LAST_IDX        = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [31:0] PAD_ONE_WORD    = 32'h8000_0000;

  // Keep bytes [0, nbytes), put the 0x80 marker at byte[nbytes], zero the rest.
  // Byte 0 sits in [31:24]; nbytes >= 4 leaves the word untouched.
  function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                input logic [2:0]  nbytes);
    logic [31:0] w;
    w = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes) begin
        w[31-8*i -: 8] = data[31-8*i -: 8];
      end else if (3'(i) == nbytes) begin
        w[31-8*i -: 8] = 8'h80;
      end else begin
        w[31-8*i -: 8] = 8'h00;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sha256_pad_ctrl.sv
// Streaming SHA-256 padder: passes message words through, then appends the
// 0x80 marker, zero fill and 64-bit bit length, 16 words per block.
module sha256_pad_ctrl
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        in_nbytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_block_start,
  output logic              out_block_end,
  output logic              out_msg_end,
  output logic              busy
);

  pad_state_e  state_r;
  logic [3:0]  widx_r;
  logic [63:0] len_bits_r;

  logic        load_s;
  logic [2:0]  nbytes_s;
  logic [3:0]  widx_nxt_s;
  pad_state_e  fill_next_s;

  assign load_s     = !out_valid || out_ready;
  assign in_ready   = (state_r == ST_DATA) && load_s;
  assign nbytes_s   = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign widx_nxt_s = widx_r + 4'd1;

  // After a marker or zero word: if the next slot is the length slot, go
  // straight to LEN_HI so the padding streams without a bubble.
  always_comb begin
    fill_next_s = ST_ZERO;
    if (widx_nxt_s == LEN_HI_IDX) begin
      fill_next_s = ST_LEN_HI;
    end else begin
      fill_next_s = ST_ZERO;
    end
  end

  // Padding FSM, word/length counters and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_DATA;
      widx_r          <= 4'd0;
      len_bits_r      <= 64'd0;
      out_valid       <= 1'b0;
      out_data        <= 32'h0000_0000;
      out_block_start <= 1'b0;
      out_block_end   <= 1'b0;
      out_msg_end     <= 1'b0;
      busy            <= 1'b0;
    end else if (load_s) begin
      case (state_r)
        ST_DATA: begin
          if (in_valid) begin
            out_valid       <= 1'b1;
            busy            <= 1'b1;
            out_block_start <= (widx_r == 4'd0);
            out_block_end   <= (widx_r == LAST_IDX);
            out_msg_end     <= 1'b0;
            widx_r          <= widx_nxt_s;
            if (in_last) begin
              out_data   <= pad_last_word(in_data, nbytes_s);
              len_bits_r <= len_bits_r + {58'd0, nbytes_s, 3'd0};
              if (nbytes_s == 3'd4) begin
                state_r <= ST_ONE;
              end else begin
                state_r <= fill_next_s;
              end
            end else begin
              out_data   <= in_data;
              len_bits_r <= len_bits_r + 64'd32;
              state_r    <= ST_DATA;
            end
          end else begin
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            out_msg_end <= 1'b0;
          end
        end
        ST_ONE: begin
          out_valid       <= 1'b1;
          busy            <= 1'b1;
          out_data        <= PAD_ONE_WORD;
          out_block_start <= (widx_r == 4'd0);
          out_block_end   <= (widx_r == LAST_IDX);
          out_msg_end     <= 1'b0;
          widx_r          <= widx_nxt_s;
          state_r         <= fill_next_s;
        end
        ST_ZERO: begin
          if (widx_r == LEN_HI_IDX) begin
            // Length slot reached without emitting; normally skipped above.
            out_valid <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_LEN_HI;
          end else begin
            out_valid       <= 1'b1;
            busy            <= 1'b1;
            out_data        <= 32'h0000_0000;
            out_block_start <= (widx_r == 4'd0);
            out_block_end   <= (widx_r == LAST_IDX);
            out_msg_end     <= 1'b0;
            widx_r          <= widx_nxt_s;
            state_r         <= fill_next_s;
          end
        end
        ST_LEN_HI: begin
          out_valid       <= 1'b1;
          busy            <= 1'b1;
          out_data        <= len_bits_r[63:32];
          out_block_start <= (widx_r == 4'd0);
          out_block_end   <= (widx_r == LAST_IDX);
          out_msg_end     <= 1'b0;
          widx_r          <= widx_nxt_s;
          state_r         <= ST_LEN_LO;
        end
        ST_LEN_LO: begin
          out_valid       <= 1'b1;
          busy            <= 1'b1;
          out_data        <= len_bits_r[31:0];
          out_block_start <= (widx_r == 4'd0);
          out_block_end   <= (widx_r == LAST_IDX);
          out_msg_end     <= 1'b1;
          widx_r          <= widx_nxt_s;
          len_bits_r      <= 64'd0;
          state_r         <= ST_DATA;
        end
        default: begin
          state_r     <= ST_DATA;
          out_valid   <= 1'b0;
          busy        <= 1'b0;
          out_msg_end <= 1'b0;
        end
      endcase
    end else begin
      // Downstream stalled: hold the presented word and all state.
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Self-checking bench for sha256_pad_ctrl: random and directed messages are
// compared against a byte-level FIPS 180-4 padding model.
module tb_sha256_pad_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_block_start;
  logic        out_block_end;
  logic        out_msg_end;
  logic        busy;

  int checks = 0;
  int errors = 0;

  byte unsigned pool[$];
  int           lens_q[$];
  logic [31:0]  exp_data[$];
  logic [2:0]   exp_flags[$];
  logic [31:0]  obs_data[$];
  logic [2:0]   obs_flags[$];

  sha256_pad_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .in_nbytes       (in_nbytes),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_block_start (out_block_start),
    .out_block_end   (out_block_end),
    .out_msg_end     (out_msg_end),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // FIPS 180-4 padding of one message, appended to the expected stream.
  task automatic model(input byte unsigned m[$]);
    byte unsigned p[$];
    longint unsigned bits;
    int nw;
    p = m;
    bits = longint'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int b = 7; b >= 0; b--) p.push_back(8'(bits >> (8 * b)));
    nw = p.size() / 4;
    for (int i = 0; i < nw; i++) begin
      exp_data.push_back({p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
      exp_flags.push_back({(i % 16) == 0, (i % 16) == 15, i == nw - 1});
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) pool.push_back(8'($urandom_range(255, 0)));
  endtask

  // Drive the messages in lens_q back to back (bytes from pool) and check output.
  task automatic run(input string name, input bit bp, input bit tail_rand);
    logic [31:0]  wd[$];
    bit           wl[$];
    logic [2:0]   wn[$];
    byte unsigned m[$];
    logic [31:0]  w, prev_data;
    logic [2:0]   prev_flags;
    int full, rem, wi, cyc, nexp;
    bit hs_in, hs_out, stalled, pad_phase;
    exp_data.delete(); exp_flags.delete(); obs_data.delete(); obs_flags.delete();
    foreach (lens_q[k]) begin
      m.delete();
      for (int j = 0; j < lens_q[k]; j++) m.push_back(pool.pop_front());
      model(m);
      full = lens_q[k] / 4;
      rem  = lens_q[k] % 4;
      for (int j = 0; j < full; j++) begin
        wd.push_back({m[4*j], m[4*j+1], m[4*j+2], m[4*j+3]});
        wl.push_back(1'b0);
        wn.push_back(3'd4);
      end
      if (rem != 0) begin
        w = $urandom();
        for (int b = 0; b < rem; b++) w[31-8*b -: 8] = m[4*full+b];
        wd.push_back(w); wl.push_back(1'b1); wn.push_back(3'(rem));
      end else if (full == 0 || (tail_rand && ($urandom_range(1, 0) == 1))) begin
        wd.push_back($urandom()); wl.push_back(1'b1); wn.push_back(3'd0);
      end else begin
        wl[wl.size()-1] = 1'b1;
      end
    end
    nexp = exp_data.size();
    wi = 0; cyc = 0; hs_in = 0; stalled = 0; pad_phase = 0;
    prev_data = 32'h0; prev_flags = 3'h0;
    in_valid = 1'b0;
    while ((obs_data.size() < nexp) && (cyc < 4000)) begin
      @(negedge clk);
      cyc++;
      if (hs_in) begin
        wi++;
        in_valid = 1'b0;
      end
      if (wi < wd.size()) begin
        if (!in_valid) in_valid = bp ? ($urandom_range(3, 0) != 0) : 1'b1;
        in_data = wd[wi]; in_last = wl[wi]; in_nbytes = wn[wi];
      end else begin
        in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; in_nbytes = 3'd0;
      end
      out_ready = bp ? ($urandom_range(2, 0) != 0) : 1'b1;
      #1;
      if (stalled) begin
        chk({name, "_stable_data"}, 64'(out_data), 64'(prev_data));
        chk({name, "_stable_flags"}, 64'({out_block_start, out_block_end, out_msg_end}), 64'(prev_flags));
      end
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        obs_data.push_back(out_data);
        obs_flags.push_back({out_block_start, out_block_end, out_msg_end});
        if (out_msg_end) begin
          pad_phase = 1'b0;
          if (in_valid) chk({name, "_b2b_in_ready"}, 64'(in_ready), 64'd1);
        end
      end
      if (pad_phase) begin
        chk({name, "_pad_in_ready"}, 64'(in_ready), 64'd0);
        chk({name, "_pad_busy"}, 64'(busy), 64'd1);
      end
      hs_in = in_valid && in_ready;
      if (hs_in && in_last) pad_phase = 1'b1;
      stalled    = out_valid && !out_ready;
      prev_data  = out_data;
      prev_flags = {out_block_start, out_block_end, out_msg_end};
    end
    chk({name, "_word_count"}, 64'(obs_data.size()), 64'(nexp));
    chk({name, "_inputs_used"}, 64'(wi), 64'(wd.size()));
    for (int i = 0; i < nexp && i < obs_data.size(); i++) begin
      chk($sformatf("%s_data[%0d]", name, i), 64'(obs_data[i]), 64'(exp_data[i]));
      chk($sformatf("%s_flags[%0d]", name, i), 64'(obs_flags[i]), 64'(exp_flags[i]));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk({name, "_idle_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    in_nbytes = 3'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_flags", 64'({out_block_start, out_block_end, out_msg_end}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // "abc"
    pool = {8'h61, 8'h62, 8'h63};
    lens_q = {3};
    run("abc", 1'b0, 1'b0);
    chk("abc_first", 64'(obs_data[0]), 64'h6162_6380);
    chk("abc_len", 64'(obs_data[15]), 64'h0000_0018);

    // Empty message
    lens_q = {0};
    run("empty", 1'b0, 1'b0);
    chk("empty_first", 64'(obs_data[0]), 64'h8000_0000);
    chk("empty_len", 64'(obs_data[15]), 64'h0);

    // 56 bytes: marker at index 14, length in a second block
    fill_rand(56); lens_q = {56};
    run("b56", 1'b0, 1'b0);
    chk("b56_marker", 64'(obs_data[14]), 64'h8000_0000);
    chk("b56_len", 64'(obs_data[31]), 64'h0000_01C0);

    // 64 bytes: one full data block then a padding block
    fill_rand(64); lens_q = {64};
    run("b64", 1'b0, 1'b0);
    chk("b64_marker", 64'(obs_data[16]), 64'h8000_0000);
    chk("b64_len", 64'(obs_data[31]), 64'h0000_0200);

    // 56 bytes under random backpressure and input gaps
    fill_rand(56); lens_q = {56};
    run("b56_bp", 1'b1, 1'b0);

    // Random back-to-back messages, with and without backpressure
    lens_q = {};
    for (int k = 0; k < 6; k++) begin
      lens_q.push_back($urandom_range(130, 0));
      fill_rand(lens_q[k]);
    end
    run("rand_b2b", 1'b0, 1'b1);
    lens_q = {};
    for (int k = 0; k < 6; k++) begin
      lens_q.push_back($urandom_range(130, 0));
      fill_rand(lens_q[k]);
    end
    run("rand_bp", 1'b1, 1'b1);

    // Reset in the middle of zero fill, then a clean "abc"
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h6162_63A5; in_last = 1'b1; in_nbytes = 3'd3; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_in_zero_valid", 64'(out_valid), 64'd1);
    chk("midrst_in_zero_data", 64'(out_data), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_flags", 64'({out_block_start, out_block_end, out_msg_end}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pool = {8'h61, 8'h62, 8'h63};
    lens_q = {3};
    run("post_rst_abc", 1'b0, 1'b0);
    chk("post_rst_first", 64'(obs_data[0]), 64'h6162_6380);
    chk("post_rst_len", 64'(obs_data[15]), 64'h0000_0018);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_pad_ctrl.md
# sha256_pad_ctrl

- Streaming SHA-256 message padder and block sequencer.
- Accepts an arbitrary-length message as big-endian 32-bit words and emits the padded word stream to the compression core, 16 words per 512-bit block.
- Padding follows FIPS 180-4: a 0x80 marker, zero fill, then the 64-bit big-endian bit length.
- Flags on the output stream mark the first word of each block, the last word of each block, and the final block of the message.

## Interface
- Parameters: none. Word width (32) and block length (16 words) are fixed constants in `sha256_pkg`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid && in_ready`.
- `in_data`  in  32  message word, big-endian (byte 0 in [31:24]).
- `in_last`  in  1  final word of the message.
- `in_nbytes`  in  3  valid bytes in the final word, 0..4. Sampled only with `in_last`. 0 is legal only for an empty or byte-exhausted message.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  32  padded stream word.
- `out_block_start`  out  1  word index 0 of a block.
- `out_block_end`  out  1  word index 15 of a block.
- `out_msg_end`  out  1  word index 15 of the final block of the message.
- `busy`  out  1  high in any state other than DATA, or while `out_valid` is high.

## Operation
- Output is a registered skid-less stage: `out_*` registers load when `!out_valid || out_ready`.
- `in_ready = (state==DATA) && (!out_valid || out_ready)`.
- Counters:
  - `widx[3:0]`: index of the next word to be emitted; wraps 15→0.
  - `len_bits[63:0]`: adds 32 per non-final word and 8*`in_nbytes` on the final word; wraps mod 2^64.
- States and transitions:
  - **DATA**
    - Non-last word: emit `in_data` unchanged.
    - Last word with `in_nbytes` < 4: emit the valid bytes, with byte[`in_nbytes`] = 0x80 and the remaining bytes 0. Go to ZERO.
    - Last word with `in_nbytes` = 4: emit the word unchanged. Go to ONE.
  - **ONE**: emit 0x80000000, then go to ZERO.
  - **ZERO**
    - Emit 0x00000000 while `widx` != 14.
    - When `widx` = 14 is reached, go to LEN_HI without emitting.
    - If the marker landed at index 14 or 15, zero fill continues through index 15 and into the next block up to index 13.
  - **LEN_HI**: emit `len_bits[63:32]`, then go to LEN_LO.
  - **LEN_LO**
    - Emit `len_bits[31:0]` with `out_msg_end` = 1.
    - Clear `len_bits`, then go to DATA.
- Input bytes beyond `in_nbytes` are masked to 0 regardless of their value.
- Flags are derived from `widx` of the emitted word:
  - `out_block_start = (widx==0)`
  - `out_block_end = (widx==15)`
- Reset values:
  - State: DATA.
  - Outputs: `out_valid`, `out_data`, all flags, and `busy` are 0.
  - Counters: `widx` and `len_bits` are 0.

## Timing
- Latency is 1 cycle: a word accepted at edge N is presented on `out_*` after edge N.
- Throughput is 1 word/cycle with `out_ready` held high. Padding words also stream at 1/cycle.
- While `in_valid` is held, the input stalls from the cycle after the last word is accepted until the cycle after LEN_LO is accepted.
- Back-to-back messages: the first word of the next message is accepted in the same cycle LEN_LO leaves the output register.
- Backpressure: `out_data` and flags are stable while `out_valid && !out_ready`. No word is dropped or duplicated.
- Reset asserted mid-operation (any state):
  - All outputs and counters clear immediately.
  - The partial message is discarded.
  - The next message starts at `widx` = 0 and `len_bits` = 0.

## Structure
- `sha256_pkg` holds:
  - the state enum (DATA, ONE, ZERO, LEN_HI, LEN_LO);
  - `PAD_ONE_WORD` = 32'h8000_0000, `WORDS_PER_BLOCK` = 16, `LEN_HI_IDX` = 14;
  - function `pad_last_word(data, nbytes)` for byte masking and marker insertion.
- No sub-module. The FSM, counters and output register live in `sha256_pad_ctrl`.

## Test plan
- **"abc"**: 0x61626300 with `in_last`, nbytes=3. Expect 16 words: 0x61626380, 13× 0x00000000, 0x00000000, 0x00000018. Flags: start on word 0; end and msg_end on word 15.
- **Empty message**: `in_last`, nbytes=0. Expect 0x80000000, 14× 0x0, 0x00000000. Total 16 words; length field = 0.
- **56 bytes**: 14 full words, last with nbytes=4. Expect:
  - Block 1: 14 data words, 0x80000000 at index 14, 0x0 at index 15 (end=1, msg_end=0).
  - Block 2: 14 zeros, then 0x00000000, 0x000001C0 with msg_end=1.
- **64 bytes**: 16 full words. Expect:
  - Block 1: data only.
  - Block 2: 0x80000000, 13 zeros, 0x0, 0x00000200.
- **Backpressure**: rerun the 56-byte case with random `out_ready` and `in_valid` gaps. Expect:
  - The identical 32-word sequence.
  - `out_data` stable whenever stalled.
  - `in_ready` low through the padding states.
- **Reset mid-ZERO**: pulse `rst` during zero fill. Expect `out_valid` = 0 immediately. A following "abc" message produces the exact first-scenario output, length 0x18.
